// File: rtl/dcm_pkg.sv
// Shared constants, state encoding and sizing helpers for the dark-channel
// window-minimum stage.
package dcm_pkg;

  localparam int DCM_DATA_W   = 20;
  localparam int DCM_CHANNELS = 3;
  localparam int DCM_WIN      = 3;
  localparam int DCM_LINE_W   = 640;

  typedef enum logic {RUN, FLUSH} state_e;

  // Half-width of the centred window.
  function automatic int calc_r(input int win);
    return (win - 1) / 2;
  endfunction

  // Row position counter width; kept at least one bit wide.
  function automatic int calc_cw(input int line_w);
    return (line_w > 1) ? $clog2(line_w) : 1;
  endfunction

endpackage

// File: rtl/min_max_reduce.sv
// Combinational N-input unsigned min/max reducer. Masked-off inputs are ignored.
module min_max_reduce #(
  parameter int N = 3,
  parameter int W = 20
) (
  input  logic [N*W-1:0] data_i,
  input  logic [N-1:0]   valid_i,
  input  logic           mode_max_i,
  output logic [W-1:0]   result_o
);

  logic [W-1:0] best;
  logic [W-1:0] cand;

  // Start from the identity of the chosen operation so masked inputs never win.
  always_comb begin
    best = mode_max_i ? '0 : '1;
    cand = '0;
    for (int i = 0; i < N; i++) begin
      cand = data_i[i*W +: W];
      if (valid_i[i]) begin
        if (mode_max_i ? (cand > best) : (cand < best)) begin
          best = cand;
        end
      end
    end
  end

  assign result_o = best;

endmodule

// File: rtl/dark_channel_win_min.sv
// Streaming dark-channel stage: per-pixel channel minimum, then a centred,
// row-clipped sliding-window minimum. Optional max mode via DCM_MAX_MODE_EN.
module dark_channel_win_min
  import dcm_pkg::*;
#(
  parameter int DATA_W   = DCM_DATA_W,
  parameter int CHANNELS = DCM_CHANNELS,
  parameter int WIN      = DCM_WIN,
  parameter int LINE_W   = DCM_LINE_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_last
`ifdef DCM_MAX_MODE_EN
  ,
  input  logic                       mode_max
`endif
);

  localparam int R  = calc_r(WIN);
  localparam int CW = calc_cw(LINE_W);
  localparam logic [CW-1:0] R_X    = CW'(R);
  localparam logic [CW-1:0] LAST_X = CW'(LINE_W - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     in_x_q, in_x_d, out_x_q, out_x_d;
  logic [DATA_W-1:0] win_q [WIN];
  logic [DATA_W-1:0] win_d [WIN];
  logic [WIN-1:0]    vld_q, vld_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  logic                  free, accept, flush_go, load, mode_cur;
  logic [DATA_W-1:0]     chan_min, win_res;
  logic [WIN*DATA_W-1:0] cand_flat;
  logic [WIN-1:0]        cand_vld;

  assign free     = !out_valid_q || out_ready;
  assign in_ready = rst_n && (state_q == RUN) && free;
  assign accept   = in_valid && in_ready;
  assign flush_go = (state_q == FLUSH) && free;
  assign load     = (accept && (in_x_q >= R_X)) || flush_go;

`ifdef DCM_MAX_MODE_EN
  logic mode_q;
  // The mode is latched on the first pixel of a row and held until the next one.
  assign mode_cur = (state_q == RUN && in_x_q == '0) ? mode_max : mode_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
    end else if (accept && in_x_q == '0) begin
      mode_q <= mode_max;
    end
  end
`else
  assign mode_cur = 1'b0;
`endif

  min_max_reduce #(.N(CHANNELS), .W(DATA_W)) u_chan_reduce (
    .data_i     (in_data),
    .valid_i    ({CHANNELS{1'b1}}),
    .mode_max_i (mode_cur),
    .result_o   (chan_min)
  );

  // Buffer contents as they will be after this cycle's shift; flush shifts in a hole.
  always_comb begin
    cand_flat           = '0;
    cand_vld            = '0;
    cand_flat[DATA_W-1:0] = chan_min;
    cand_vld[0]         = (state_q == RUN);
    for (int i = 1; i < WIN; i++) begin
      cand_flat[i*DATA_W +: DATA_W] = win_q[i-1];
      cand_vld[i]                   = vld_q[i-1];
    end
  end

  min_max_reduce #(.N(WIN), .W(DATA_W)) u_win_reduce (
    .data_i     (cand_flat),
    .valid_i    (cand_vld),
    .mode_max_i (mode_cur),
    .result_o   (win_res)
  );

  always_comb begin
    state_d     = state_q;
    in_x_d      = in_x_q;
    out_x_d     = out_x_q;
    win_d       = win_q;
    vld_d       = vld_q;
    out_valid_d = out_ready ? 1'b0 : out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (accept || flush_go) begin
      for (int i = 0; i < WIN; i++) begin
        win_d[i] = cand_flat[i*DATA_W +: DATA_W];
      end
      vld_d = cand_vld;
    end

    if (accept) begin
      in_x_d = (in_x_q == LAST_X) ? '0 : in_x_q + 1'b1;
      if (in_x_q == LAST_X && R > 0) begin
        state_d = FLUSH;
      end
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = win_res;
      out_last_d  = (out_x_q == LAST_X);
      out_x_d     = (out_x_q == LAST_X) ? '0 : out_x_q + 1'b1;
      // Emptying the buffer here keeps this row's pixels out of the next row.
      if (flush_go && out_x_q == LAST_X) begin
        vld_d   = '0;
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      in_x_q      <= '0;
      out_x_q     <= '0;
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < WIN; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      in_x_q      <= in_x_d;
      out_x_q     <= out_x_d;
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      win_q       <= win_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_dark_channel_win_min.sv
// Self-checking bench for dark_channel_win_min: randomized rows, gaps and
// backpressure scored against a row-level reference model.
module tb_dark_channel_win_min;

  localparam int DW = 20;
  localparam int CH = 3;
  localparam int WN = 3;
  localparam int LW = 4;
  localparam int RR = (WN - 1) / 2;

  typedef logic [CH*DW-1:0] pix_t;
  typedef pix_t rowArr_t [LW];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  pix_t          in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
`ifdef DCM_MAX_MODE_EN
  logic          mode_max = 1'b0;
`endif

  int            nChecks = 0;
  int            nErrors = 0;
  bit            bpEn = 1'b0;
  logic [DW:0]   expQ[$];
  logic [DW:0]   expHead;
  bit            heldValid = 1'b0;
  logic [DW-1:0] heldData;
  logic          heldLast;

  dark_channel_win_min #(
    .DATA_W   (DW),
    .CHANNELS (CH),
    .WIN      (WN),
    .LINE_W   (LW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef DCM_MAX_MODE_EN
    .mode_max  (mode_max),
`endif
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pix_t pk(input int a, input int b, input int c);
    pix_t p;
    p = '0;
    p[0*DW +: DW] = DW'(a);
    p[1*DW +: DW] = DW'(b);
    p[2*DW +: DW] = DW'(c);
    return p;
  endfunction

  function automatic logic [DW-1:0] pixRed(input pix_t p, input bit mx);
    logic [DW-1:0] best, comp;
    best = p[DW-1:0];
    for (int c = 1; c < CH; c++) begin
      comp = p[c*DW +: DW];
      if (mx ? (comp > best) : (comp < best)) best = comp;
    end
    return best;
  endfunction

  // Reference: each output x reduces the per-pixel results over [x-R, x+R] within the row.
  function automatic void modelRow(input rowArr_t row, input bit mx);
    logic [DW-1:0] pm [LW];
    logic [DW-1:0] best;
    for (int x = 0; x < LW; x++) pm[x] = pixRed(row[x], mx);
    for (int x = 0; x < LW; x++) begin
      best = pm[x];
      for (int j = x - RR; j <= x + RR; j++) begin
        if (j >= 0 && j < LW) begin
          if (mx ? (pm[j] > best) : (pm[j] < best)) best = pm[j];
        end
      end
      expQ.push_back({(x == LW - 1), best});
    end
  endfunction

  // Random or steady downstream readiness, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    out_ready = bpEn ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Output scoreboard and hold checks, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      heldValid = 1'b0;
    end else if (out_valid) begin
      if (heldValid) begin
        checkOutput("hold_data", out_data, heldData);
        checkOutput("hold_last", out_last, heldLast);
      end
      if (out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_sample", expQ.size(), 1);
        end else begin
          expHead = expQ.pop_front();
          checkOutput("out_data", out_data, expHead[DW-1:0]);
          checkOutput("out_last", out_last, expHead[DW]);
        end
        heldValid = 1'b0;
      end else begin
        heldValid = 1'b1;
        heldData  = out_data;
        heldLast  = out_last;
        checkOutput("inready_stall", in_ready, 0);
      end
    end else begin
      heldValid = 1'b0;
    end
  end

  task automatic applyStimulus(input rowArr_t row, input bit gaps, input bit rowMode,
                               output int firstStall);
    int  stalls;
    bit  acc;
    modelRow(row, rowMode);
    firstStall = 0;
`ifdef DCM_MAX_MODE_EN
    mode_max = rowMode;
`endif
    for (int x = 0; x < LW; x++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = row[x];
      stalls   = 0;
      acc      = 1'b0;
      while (!acc && stalls < 100) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        if (!acc) stalls++;
      end
      if (!acc) checkOutput("accept_timeout", stalls, 0);
      if (x == 0) firstStall = stalls;
      if (!bpEn && x >= RR) checkOutput("latency", out_valid, 1);
`ifdef DCM_MAX_MODE_EN
      mode_max = 1'($urandom);
`endif
    end
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int cnt;
    cnt = 0;
    while ((expQ.size() != 0 || out_valid) && cnt < 200) begin
      @(posedge clk);
      cnt++;
    end
    #1;
    checkOutput("drain", expQ.size(), 0);
  endtask

  initial begin
    rowArr_t basic, ones, rnd;
    int      stall;
    bit      rndMode;

    basic[0] = pk(10, 20, 30);
    basic[1] = pk(5, 9, 7);
    basic[2] = pk(40, 41, 42);
    basic[3] = pk(8, 100, 3);
    for (int x = 0; x < LW; x++) ones[x] = pk(20'hFFFFF, 20'hFFFFF, 20'hFFFFF);

    in_valid = 1'b1;
    #2;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    in_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic row, no backpressure");
    applyStimulus(basic, 1'b0, 1'b0, stall);
    waitDrain();

    $display("[TB] basic row with idle gaps");
    applyStimulus(basic, 1'b1, 1'b0, stall);
    waitDrain();

    $display("[TB] basic row with backpressure");
    bpEn = 1'b1;
    applyStimulus(basic, 1'b0, 1'b0, stall);
    waitDrain();
    bpEn = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] back-to-back rows");
    applyStimulus(basic, 1'b0, 1'b0, stall);
    applyStimulus(ones, 1'b0, 1'b0, stall);
    checkOutput("row_gap_stall", stall, 1);
    waitDrain();

    $display("[TB] reset during flush");
    applyStimulus(basic, 1'b0, 1'b0, stall);
    checkOutput("flush_in_ready", in_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", out_valid, 0);
    checkOutput("async_in_ready", in_ready, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(ones, 1'b0, 1'b0, stall);
    waitDrain();

`ifdef DCM_MAX_MODE_EN
    $display("[TB] max mode row");
    applyStimulus(basic, 1'b0, 1'b1, stall);
    waitDrain();
`endif

    $display("[TB] randomized rows");
    for (int r = 0; r < 20; r++) begin
      for (int x = 0; x < LW; x++) begin
        if (r % 2 == 0)
          rnd[x] = pk($urandom_range(0, 20'hFFFFF), $urandom_range(0, 20'hFFFFF),
                      $urandom_range(0, 20'hFFFFF));
        else
          rnd[x] = pk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      end
      rndMode = 1'b0;
`ifdef DCM_MAX_MODE_EN
      rndMode = 1'($urandom);
`endif
      bpEn = 1'($urandom);
      applyStimulus(rnd, 1'($urandom), rndMode, stall);
      if (r % 4 == 3) waitDrain();
    end
    waitDrain();
    bpEn = 1'b0;

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
